quant_code_gen: RTL and testbench

- Stage directly downstream of the float32 multiplier in the SZ first-stage datapath.
- Input is the prediction error already scaled by 1/(2·eb), arriving as an IEEE-754 single.
- Converts each sample to a linear-quantization code by round-half-away-from-zero, range-checks it against the interval capacity, and flags unpredictable points.
- Pipelined, valid/ready with stall; also keeps per-run point and unpredictable counters.

---
 rtl/quant_code_gen.sv | 90 +++++++++
 tb/tb_quant_code_gen.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/quant_code_gen.sv
// quant_code_gen: float32 scaled error to linear-quantization code with range check and run counters
module quant_code_gen #(
    parameter int QUANT_BITS = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           in_data,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [QUANT_BITS-1:0] out_code,
    output logic                  out_unpred,
    output logic                  out_last,
    output logic [31:0]           pt_count,
    output logic [31:0]           unpred_count
);
    localparam int QB = QUANT_BITS;
    localparam logic [QB-1:0] R = {1'b1, {(QB-1){1'b0}}};

    logic          en, hs, clr;
    logic          v1, sign1, unpred1, last1;
    logic [4:0]    sh1;
    logic [23:0]   sig1;
    logic          v2, sign2, unpred2, last2;
    logic [QB:0]   m2;
    logic [7:0]    exp_in;
    logic          ovf;
    logic [QB-1:0] code;

    assign en       = !out_valid | out_ready;
    assign in_ready = en;
    assign hs       = out_valid & out_ready;
    assign exp_in   = in_data[30:23];

    // Range check and bias: magnitudes at or beyond R cannot be coded and map to 0
    always_comb begin
        ovf  = unpred2 | m2[QB] | m2[QB-1];
        code = ovf ? '0 : sign2 ? R - m2[QB-1:0] : R + m2[QB-1:0];
    end

    // Three pipeline stages advancing together on en; shift amount is 22-e so the
    // significand lands with one fraction bit left for the half-away rounding add
    always_ff @(posedge clk) begin
        if (rst) begin
            v1         <= 1'b0;
            v2         <= 1'b0;
            out_valid  <= 1'b0;
            out_code   <= '0;
            out_unpred <= 1'b0;
            out_last   <= 1'b0;
        end else if (en) begin
            v1         <= in_valid;
            sign1      <= in_data[31];
            unpred1    <= {1'b0, exp_in} >= 9'(126 + QB);
            sig1       <= exp_in <= 8'd125 ? 24'd0 : {1'b1, in_data[22:0]};
            sh1        <= 5'(8'd149 - exp_in);
            last1      <= in_last;
            v2         <= v1;
            sign2      <= sign1;
            unpred2    <= unpred1;
            m2         <= (QB+1)'(({1'b0, sig1 >> sh1} + 25'd1) >> 1);
            last2      <= last1;
            out_valid  <= v2;
            out_code   <= code;
            out_unpred <= ovf;
            out_last   <= last2;
        end
    end

    // Per-block counters: after a last-sample handshake the totals stay visible one
    // cycle, then restart from zero, counting any sample handed over in that cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            pt_count     <= '0;
            unpred_count <= '0;
            clr          <= 1'b0;
        end else begin
            clr <= hs & out_last;
            if (clr) begin
                pt_count     <= {31'd0, hs};
                unpred_count <= {31'd0, hs & out_unpred};
            end else if (hs) begin
                pt_count     <= pt_count + 32'd1;
                unpred_count <= unpred_count + {31'd0, out_unpred & ~&unpred_count};
            end
        end
    end
endmodule

// File: tb/tb_quant_code_gen.sv
// tb_quant_code_gen: directed checks of quant_code_gen rounding, range, stall, block counters and reset
module tb_quant_code_gen;
    logic        clk = 0;
    logic        rst = 1;
    logic        in_valid = 0;
    logic        in_ready;
    logic [31:0] in_data = 0;
    logic        in_last = 0;
    logic        out_valid;
    logic        out_ready = 1;
    logic [15:0] out_code;
    logic        out_unpred;
    logic        out_last;
    logic [31:0] pt_count;
    logic [31:0] unpred_count;

    int total = 0;
    int bad = 0;

    logic [31:0] din [8];
    logic [15:0] ecode [8];
    logic        eunp [8];
    logic        lst [8];

    quant_code_gen #(.QUANT_BITS(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .out_valid(out_valid),
        .out_ready(out_ready), .out_code(out_code), .out_unpred(out_unpred),
        .out_last(out_last), .pt_count(pt_count), .unpred_count(unpred_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic set(input int i, input logic [31:0] d, input logic [15:0] c, input logic u, input logic l);
        din[i] = d;
        ecode[i] = c;
        eunp[i] = u;
        lst[i] = l;
    endtask

    task automatic do_reset();
        rst = 1;
        in_valid = 0;
        in_last = 0;
        out_ready = 1;
        step();
        rst = 0;
    endtask

    // Streams n samples, stalling out_ready in cycles [s0,s1), checking every handshake in order
    task automatic run(input int n, input int s0, input int s1, input bit lat);
        int sent = 0;
        int recv = 0;
        logic [15:0] prev = 0;
        for (int c = 0; c < 60 && recv < n; c++) begin
            out_ready = !(c >= s0 && c < s1);
            in_valid = sent < n;
            in_data = din[sent];
            in_last = lst[sent];
            #2;
            if (out_valid && out_ready) begin
                chk("code", out_code, ecode[recv]);
                chk("unpred", out_unpred, eunp[recv]);
                chk("last", out_last, lst[recv]);
                if (lat) chk("latency", c, 3 + recv);
                recv++;
            end
            if (out_valid && !out_ready) begin
                chk("stall_in_ready", in_ready, 0);
                if (c > s0) chk("stall_hold", out_code, prev);
            end
            prev = out_code;
            if (in_valid && in_ready) sent++;
            step();
        end
        in_valid = 0;
        in_last = 0;
        out_ready = 1;
        chk("received_all", recv, n);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) set(i, 0, 16'd32768, 0, 0);
        step();
        do_reset();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_code", out_code, 0);
        chk("rst_out_unpred", out_unpred, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_pt", pt_count, 0);
        chk("rst_unpred_cnt", unpred_count, 0);

        set(0, 32'h3FC00000, 16'd32770, 0, 0);
        set(1, 32'hBF000000, 16'd32767, 0, 0);
        set(2, 32'h3EFFFFFF, 16'd32768, 0, 0);
        run(3, 100, 100, 1);
        chk("t1_pt", pt_count, 3);
        chk("t1_unpred_cnt", unpred_count, 0);

        do_reset();
        set(0, 32'h46FFFE00, 16'd65535, 0, 0);
        set(1, 32'h46FFFF00, 16'd0, 1, 0);
        set(2, 32'h47000000, 16'd0, 1, 0);
        set(3, 32'hC6FFFE00, 16'd1, 0, 0);
        run(4, 100, 100, 1);
        chk("t2_pt", pt_count, 4);
        chk("t2_unpred_cnt", unpred_count, 2);

        do_reset();
        set(0, 32'h7FC00000, 16'd0, 1, 0);
        set(1, 32'h7F800000, 16'd0, 1, 0);
        set(2, 32'h00000001, 16'd32768, 0, 0);
        set(3, 32'h80000000, 16'd32768, 0, 0);
        run(4, 100, 100, 1);
        chk("t3_unpred_cnt", unpred_count, 2);

        do_reset();
        set(0, 32'h3F800000, 16'd32769, 0, 0);
        set(1, 32'h40000000, 16'd32770, 0, 0);
        set(2, 32'h40400000, 16'd32771, 0, 0);
        set(3, 32'h40800000, 16'd32772, 0, 0);
        set(4, 32'h40A00000, 16'd32773, 0, 0);
        set(5, 32'h40C00000, 16'd32774, 0, 0);
        run(6, 4, 8, 0);
        chk("stall_pt", pt_count, 6);

        out_ready = 0;
        in_valid = 1;
        for (int i = 0; i < 3; i++) begin
            in_data = din[i];
            step();
        end
        in_valid = 0;
        chk("pre_rst_out_valid", out_valid, 1);
        rst = 1;
        step();
        rst = 0;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_pt", pt_count, 0);
        chk("midrst_unpred_cnt", unpred_count, 0);
        out_ready = 1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("midrst_flushed", out_valid, 0);
        end

        do_reset();
        set(0, 32'h3F800000, 16'd32769, 0, 0);
        set(1, 32'h7FC00000, 16'd0, 1, 0);
        set(2, 32'h40000000, 16'd32770, 0, 0);
        set(3, 32'h7F800000, 16'd0, 1, 0);
        set(4, 32'h40400000, 16'd32771, 0, 1);
        run(5, 100, 100, 1);
        chk("blk_pt", pt_count, 5);
        chk("blk_unpred_cnt", unpred_count, 2);
        step();
        chk("blk_clr_pt", pt_count, 0);
        chk("blk_clr_unpred_cnt", unpred_count, 0);
        set(0, 32'h3F800000, 16'd32769, 0, 0);
        set(4, 32'h0, 16'd32768, 0, 0);
        run(1, 100, 100, 1);
        chk("blk_next_pt", pt_count, 1);
        chk("blk_next_unpred_cnt", unpred_count, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
